bin_to_bcd_seq: RTL

Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble), one input bit per clock. It sits directly upstream of the board's 7-segment digit decoders. It takes an unsigned binary value from datapath logic and produces packed 4-bit BCD digits. Each digit nibble drives one decoder instance.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_adj.sv | 18 +
 rtl/bin_to_bcd_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Everything here is used with import bcd_pkg::* in the design files.
package bcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } bcd_state_e;

  localparam int DIGIT_W    = 4;
  localparam int ADJ_THRESH = 5;

  // Width needed to hold the bit counter value BIN_W.
  function automatic int bcd_cnt_w(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD digit add-3 adjust used before every double-dabble shift.
// A digit of 5 or more becomes >= 8, so the next shift carries it into the next digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  always_comb begin
    if (i_digit >= DIGIT_W'(ADJ_THRESH)) begin
      o_digit = i_digit + DIGIT_W'(3);
    end else begin
      o_digit = i_digit;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Define BCD_BLANK_EN to register a leading-zero mask on oBLANK; otherwise oBLANK is tied to zero.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic                  iVALID,
  input  logic [BIN_W-1:0]      iBIN,
  output logic                  oREADY,
  output logic                  oVALID,
  output logic [DIGITS*4-1:0]   oBCD,
  output logic                  oOVF,
  output logic [DIGITS-1:0]     oBLANK
);

  localparam int SCR_W = DIGITS * DIGIT_W;
  localparam int CNT_W = bcd_cnt_w(BIN_W);

  // Handshake: a value is taken at a rising edge where iVALID && oREADY; oVALID is a
  // one-cycle pulse with no back-pressure, and oBCD/oOVF hold until the next completion.
  bcd_state_e       state_q, state_d;
  logic [BIN_W-1:0] sh_q, sh_d;
  logic [SCR_W-1:0] scr_q, scr_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [SCR_W-1:0] bcd_q, bcd_d;
  logic             done;

  logic [SCR_W-1:0] adj_w;
  logic [SCR_W-1:0] scr_step;
  logic [BIN_W-1:0] sh_step;
  logic             carry_w;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (scr_q[g*DIGIT_W +: DIGIT_W]),
      .o_digit (adj_w[g*DIGIT_W +: DIGIT_W])
    );
  end

  // The bit leaving the top digit is a lost multiple of 10^DIGITS.
  assign carry_w  = adj_w[SCR_W-1];
  assign scr_step = {adj_w[SCR_W-2:0], sh_q[BIN_W-1]};
  assign sh_step  = {sh_q[BIN_W-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (iVALID && ready_q) begin
          sh_d    = iBIN;
          scr_d   = '0;
          flag_d  = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          ready_d = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        sh_d   = sh_step;
        scr_d  = scr_step;
        flag_d = flag_q | carry_w;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          done    = 1'b1;
          bcd_d   = scr_step;
          ovf_d   = flag_q | carry_w;
          valid_d = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      sh_q    <= '0;
      scr_q   <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
    end
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_step;

  // Bit i is set while digit i and everything above it is zero; digit 0 always shows.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank_step = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (scr_step[i*DIGIT_W +: DIGIT_W] == '0);
      blank_step[i] = zero_above;
    end
  end

  assign blank_d = done ? blank_step : blank_q;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign oBLANK = blank_q;
`else
  assign oBLANK = '0;
`endif

  assign oREADY = ready_q;
  assign oVALID = valid_q;
  assign oBCD   = bcd_q;
  assign oOVF   = ovf_q;

endmodule
